// File: rtl/wb_regfile_if.sv
// Bus bundle for wb_regfile: writeback, issue-reservation and read-port signals.
// The datapath side uses the master modport; the register file uses slave.
interface wb_regfile_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NUM_RD = 2
);
  logic                       wb_valid;
  logic [1:0]                 wb_sel;
  logic [DATA_W-1:0]          wb_alu;
  logic [DATA_W-1:0]          wb_mem;
  logic [DATA_W-1:0]          wb_pc;
  logic [ADDR_W-1:0]          wb_dr;
  logic                       wb_setcc;
  logic                       iss_valid;
  logic [ADDR_W-1:0]          iss_dr;
  logic                       iss_ready;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic [NUM_RD-1:0]          rd_busy;
  logic [2:0]                 psr;
  logic                       sb_err;

  modport master (
    output wb_valid, wb_sel, wb_alu, wb_mem, wb_pc, wb_dr, wb_setcc,
    output iss_valid, iss_dr, rd_addr,
    input  iss_ready, rd_data, rd_busy, psr, sb_err
  );

  modport slave (
    input  wb_valid, wb_sel, wb_alu, wb_mem, wb_pc, wb_dr, wb_setcc,
    input  iss_valid, iss_dr, rd_addr,
    output iss_ready, rd_data, rd_busy, psr, sb_err
  );
endinterface

// File: rtl/wb_regfile.sv
// LC3 writeback stage and register file: source mux, NZP update, per-register
// in-flight write scoreboard and NUM_RD combinational read ports with optional bypass.
module wb_regfile #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);
  localparam int NREG = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    SEL_ALU    = 2'd0,
    SEL_MEM    = 2'd1,
    SEL_PC     = 2'd2,
    SEL_CANCEL = 2'd3
  } wb_sel_e;

  logic [DATA_W-1:0] regs    [NREG];
  logic [CNT_W-1:0]  cnt     [NREG];
  logic [CNT_W-1:0]  cnt_nxt [NREG];
  logic [2:0]        psr_q;
  logic              sb_err_q;

  logic [DATA_W-1:0] dr_in;
  logic              we;
  logic              iss_fire;
  logic              wb_dec;
  logic              wb_underflow;
  logic [2:0]        nzp;

  // ---------------------------------------------------------------------------
  // Writeback source mux and condition codes of the value being written
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    dr_in = '0;
    unique case (wb_sel_e'(bus.wb_sel))
      SEL_ALU:    dr_in = bus.wb_alu;
      SEL_MEM:    dr_in = bus.wb_mem;
      SEL_PC:     dr_in = bus.wb_pc;
      SEL_CANCEL: dr_in = '0;
      default:    dr_in = '0;
    endcase
  end

  assign we  = bus.wb_valid && (wb_sel_e'(bus.wb_sel) != SEL_CANCEL);
  assign nzp = {dr_in[DATA_W-1], dr_in == '0, !dr_in[DATA_W-1] && (dr_in != '0)};

  // ---------------------------------------------------------------------------
  // Scoreboard: a writeback (including a cancel) releases one reservation; a
  // same-cycle writeback to the same register frees the slot for the new issue.
  // ---------------------------------------------------------------------------
  assign bus.iss_ready = (cnt[bus.iss_dr] != CNT_MAX) ||
                         (bus.wb_valid && (bus.wb_dr == bus.iss_dr) && (cnt[bus.iss_dr] != '0));
  assign iss_fire      = bus.iss_valid && bus.iss_ready;
  assign wb_dec        = bus.wb_valid && (cnt[bus.wb_dr] != '0);
  assign wb_underflow  = bus.wb_valid && (cnt[bus.wb_dr] == '0);

  always_comb begin
    for (int r = 0; r < NREG; r++) cnt_nxt[r] = cnt[r];
    if (!(iss_fire && bus.wb_valid && (bus.iss_dr == bus.wb_dr))) begin
      if (iss_fire) cnt_nxt[bus.iss_dr] = cnt[bus.iss_dr] + CNT_W'(1);
      if (wb_dec)   cnt_nxt[bus.wb_dr]  = cnt[bus.wb_dr] - CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // State: registers, counters, condition codes, sticky underflow flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the register array is small and flop-based, so clearing it on reset is cheap and gives reads a defined value.
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      psr_q    <= 3'b010;
      sb_err_q <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every process sees pre-edge values.
      for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
      if (we) regs[bus.wb_dr] <= dr_in;
      if (we && bus.wb_setcc) psr_q <= nzp;
      if (wb_underflow) sb_err_q <= 1'b1;
    end
  end

  assign bus.psr    = psr_q;
  assign bus.sb_err = sb_err_q;

  // ---------------------------------------------------------------------------
  // Read ports: a bypassed read sees the in-flight value and that write's own
  // reservation no longer counts as busy.
  // ---------------------------------------------------------------------------
  function automatic logic [ADDR_W-1:0] port_addr(input int k);
    return bus.rd_addr[k*ADDR_W +: ADDR_W];
  endfunction

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (BYPASS && we && (bus.wb_dr == port_addr(k)))
        bus.rd_data[k*DATA_W +: DATA_W] = dr_in;
      else
        bus.rd_data[k*DATA_W +: DATA_W] = regs[port_addr(k)];

      if (BYPASS && bus.wb_valid && (bus.wb_dr == port_addr(k)))
        bus.rd_busy[k] = cnt[port_addr(k)] > CNT_W'(1);
      else
        bus.rd_busy[k] = cnt[port_addr(k)] != '0;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: a behavioural model pushes expected outputs
// into a queue each cycle; they are popped and compared against both a BYPASS=1 and a BYPASS=0 instance.
module tb_wb_regfile;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NUM_RD = 2;
  localparam int CNT_W  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();
  wb_regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus_nb ();

  assign bus_nb.wb_valid  = bus.wb_valid;
  assign bus_nb.wb_sel    = bus.wb_sel;
  assign bus_nb.wb_alu    = bus.wb_alu;
  assign bus_nb.wb_mem    = bus.wb_mem;
  assign bus_nb.wb_pc     = bus.wb_pc;
  assign bus_nb.wb_dr     = bus.wb_dr;
  assign bus_nb.wb_setcc  = bus.wb_setcc;
  assign bus_nb.iss_valid = bus.iss_valid;
  assign bus_nb.iss_dr    = bus.iss_dr;
  assign bus_nb.rd_addr   = bus.rd_addr;

  wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .CNT_W(CNT_W), .BYPASS(1'b1))
    dut (.clk(clk), .rst(rst), .bus(bus));
  wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .CNT_W(CNT_W), .BYPASS(1'b0))
    dut_nb (.clk(clk), .rst(rst), .bus(bus_nb));

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] exp_q[$];

  // Reference state (the reset state, reached after the initial reset edges)
  logic [DATA_W-1:0] m_reg [8];
  logic [CNT_W-1:0]  m_cnt [8];
  logic [2:0]        m_psr;
  logic              m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 8; r++) begin
      m_reg[r] = '0;
      m_cnt[r] = '0;
    end
    m_psr = 3'b010;
    m_err = 1'b0;
  endtask

  task automatic idle_in();
    rst           = 1'b1;
    bus.wb_valid  = 1'b0;
    bus.wb_sel    = 2'd0;
    bus.wb_alu    = '0;
    bus.wb_mem    = '0;
    bus.wb_pc     = '0;
    bus.wb_dr     = '0;
    bus.wb_setcc  = 1'b0;
    bus.iss_valid = 1'b0;
    bus.iss_dr    = '0;
    bus.rd_addr   = '0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    bus.rd_addr = {ADDR_W'(a1), ADDR_W'(a0)};
  endtask

  task automatic set_wb(input int sel, input int dr, input logic [15:0] val, input logic setcc);
    bus.wb_valid = 1'b1;
    bus.wb_sel   = 2'(sel);
    bus.wb_dr    = ADDR_W'(dr);
    bus.wb_alu   = (sel == 0 || sel == 3) ? val : 16'h5A5A;
    bus.wb_mem   = (sel == 1) ? val : 16'hA5A5;
    bus.wb_pc    = (sel == 2) ? val : 16'h0F0F;
    bus.wb_setcc = setcc;
  endtask

  task automatic set_iss(input int dr);
    bus.iss_valid = 1'b1;
    bus.iss_dr    = ADDR_W'(dr);
  endtask

  // One cycle: expectations pushed from the model at mid-cycle, popped and
  // compared against both instances, then the model advances at the edge.
  task automatic step(input string lbl);
    logic [DATA_W-1:0] din;
    logic              we, rdy, fire, dec, hit;
    logic [ADDR_W-1:0] a;
    logic [1:0]        busy, busy_nb;
    logic [DATA_W-1:0] rdv [2];
    @(negedge clk);
    case (bus.wb_sel)
      2'd0:    din = bus.wb_alu;
      2'd1:    din = bus.wb_mem;
      2'd2:    din = bus.wb_pc;
      default: din = '0;
    endcase
    we  = bus.wb_valid && (bus.wb_sel != 2'd3);
    rdy = (m_cnt[bus.iss_dr] != 2'd3) ||
          (bus.wb_valid && bus.wb_dr == bus.iss_dr && m_cnt[bus.iss_dr] != 2'd0);
    for (int k = 0; k < 2; k++) begin
      a      = bus.rd_addr[k*ADDR_W +: ADDR_W];
      hit    = bus.wb_valid && (bus.wb_dr == a);
      rdv[k] = (we && bus.wb_dr == a) ? din : m_reg[a];
      busy[k]    = hit ? (m_cnt[a] > 2'd1) : (m_cnt[a] != 2'd0);
      busy_nb[k] = (m_cnt[a] != 2'd0);
    end
    exp_q.push_back(32'(rdv[0]));
    exp_q.push_back(32'(rdv[1]));
    exp_q.push_back(32'(busy));
    exp_q.push_back(32'(rdy));
    exp_q.push_back(32'(m_psr));
    exp_q.push_back(32'(m_err));
    exp_q.push_back(32'(m_reg[bus.rd_addr[ADDR_W-1:0]]));
    exp_q.push_back(32'(busy_nb));

    check({lbl, ".rd0"},    32'(bus.rd_data[15:0]),    exp_q.pop_front());
    check({lbl, ".rd1"},    32'(bus.rd_data[31:16]),   exp_q.pop_front());
    check({lbl, ".busy"},   32'(bus.rd_busy),          exp_q.pop_front());
    check({lbl, ".ready"},  32'(bus.iss_ready),        exp_q.pop_front());
    check({lbl, ".psr"},    32'(bus.psr),              exp_q.pop_front());
    check({lbl, ".sb_err"}, 32'(bus.sb_err),           exp_q.pop_front());
    check({lbl, ".nb_rd0"}, 32'(bus_nb.rd_data[15:0]), exp_q.pop_front());
    check({lbl, ".nb_busy"},32'(bus_nb.rd_busy),       exp_q.pop_front());

    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      fire = bus.iss_valid && rdy;
      dec  = bus.wb_valid && (m_cnt[bus.wb_dr] != 2'd0);
      if (bus.wb_valid && m_cnt[bus.wb_dr] == 2'd0) m_err = 1'b1;
      if (!(fire && bus.wb_valid && bus.iss_dr == bus.wb_dr)) begin
        if (fire) m_cnt[bus.iss_dr] = m_cnt[bus.iss_dr] + 2'd1;
        if (dec)  m_cnt[bus.wb_dr]  = m_cnt[bus.wb_dr] - 2'd1;
      end
      if (we) m_reg[bus.wb_dr] = din;
      if (we && bus.wb_setcc)
        m_psr = {din[15], din == 16'h0, !din[15] && din != 16'h0};
    end
    #1;
  endtask

  initial begin
    idle_in();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    idle_in(); set_rd(0, 7); step("reset");
    check("reset.ready_c", 32'(bus.iss_ready), 32'd1);
    check("reset.psr_c",   32'(bus.psr),       32'b010);

    // ALU writeback of a negative value, then a zero from memory
    idle_in(); set_iss(3); set_rd(3, 0); step("iss3");
    idle_in(); set_wb(0, 3, 16'h8001, 1'b1); set_rd(3, 0); step("alu3");
    idle_in(); set_rd(3, 0); step("read3");
    check("alu3.data_c", 32'(bus.rd_data[15:0]), 32'h8001);
    check("alu3.psr_c",  32'(bus.psr),           32'b100);
    idle_in(); set_iss(5); step("iss5");
    idle_in(); set_wb(1, 5, 16'h0000, 1'b1); set_rd(0, 5); step("mem5");
    idle_in(); set_rd(3, 5); step("read5");
    check("mem5.psr_c", 32'(bus.psr), 32'b010);

    // Bypass versus registered read on reg2
    idle_in(); set_iss(2); step("iss2a");
    idle_in(); set_wb(2, 2, 16'h1111, 1'b0); step("pc2a");
    idle_in(); set_iss(2); step("iss2b");
    idle_in(); set_wb(2, 2, 16'h3000, 1'b0); set_rd(2, 3); step("pc2b");
    idle_in(); set_rd(2, 2); step("read2");
    check("byp.data_c", 32'(bus_nb.rd_data[15:0]), 32'h3000);

    // Scoreboard saturation on reg4
    for (int i = 0; i < 3; i++) begin
      idle_in(); set_iss(4); set_rd(4, 0); step("sat_iss");
    end
    idle_in(); set_iss(4); set_rd(4, 0); step("sat_full");
    idle_in(); set_rd(4, 0); bus.iss_dr = 3'd4; #1;
    check("sat.ready_c", 32'(bus.iss_ready), 32'd0);
    idle_in(); set_iss(4); set_wb(0, 4, 16'h4444, 1'b0); set_rd(4, 0); step("sat_swap");
    for (int i = 0; i < 3; i++) begin
      idle_in(); set_wb(1, 4, 16'h4400 + 16'(i), 1'b0); set_rd(4, 4); step("sat_drain");
    end
    idle_in(); set_rd(4, 4); step("sat_done");
    check("sat.busy_c", 32'(bus.rd_busy), 32'd0);

    // Cancel releases the reservation without writing
    idle_in(); set_iss(1); set_rd(1, 0); step("can_iss");
    idle_in(); set_wb(3, 1, 16'hFFFF, 1'b1); set_rd(1, 0); step("cancel");
    idle_in(); set_rd(1, 0); step("can_read");
    check("cancel.psr_c", 32'(bus.psr), 32'b010);

    // Underflow: data written, sticky error
    idle_in(); set_wb(0, 6, 16'h0666, 1'b0); set_rd(6, 0); step("uflow");
    for (int i = 0; i < 2; i++) begin
      idle_in(); set_rd(6, 0); step("uflow_hold");
    end
    check("uflow.err_c", 32'(bus.sb_err), 32'd1);

    // Reset in the middle of traffic
    for (int i = 0; i < 3; i++) begin
      idle_in(); set_iss(0); step("mr_iss");
    end
    idle_in(); set_wb(0, 0, 16'hABCD, 1'b1); set_rd(0, 0); step("mr_wr");
    idle_in(); set_wb(0, 0, 16'h1234, 1'b1); set_iss(0); rst = 1'b0; set_rd(0, 0); step("mr_rst");
    idle_in(); set_rd(0, 6); step("mr_after");
    check("mr.data_c", 32'(bus.rd_data[15:0]), 32'h0000);
    idle_in(); set_wb(1, 0, 16'h0042, 1'b0); step("mr_late");
    idle_in(); step("mr_late_err");

    // Random traffic against the model
    for (int i = 0; i < 80; i++) begin
      idle_in();
      if ($urandom_range(0, 1) == 1)
        set_wb($urandom_range(0, 3), $urandom_range(0, 7), 16'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) != 0) set_iss($urandom_range(0, 7));
      set_rd($urandom_range(0, 7), $urandom_range(0, 7));
      step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Parametrised writeback and register-file block for the LC3 datapath, replacing the fixed 8×16 writeback stage. It selects the writeback source (ALU, memory, PC) and writes the destination register on the rising clock edge. It also updates the NZP condition codes and keeps a per-register in-flight scoreboard so the issue stage can detect hazards. Reads are combinational on NUM_RD independent ports, with optional same-cycle writeback bypass.

## Interface
- DATA_W, 16, register and datapath width
- ADDR_W, 3, register address width; NREG = 2**ADDR_W registers
- NUM_RD, 2, number of read ports
- CNT_W, 2, scoreboard counter width; at most 2**CNT_W-1 writes in flight per register
- BYPASS, 1, 1 = a read of the register being written returns the writeback value in the same cycle

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- wb_valid  in  1  writeback strobe
- wb_sel  in  2  source: 0 = wb_alu, 1 = wb_mem, 2 = wb_pc, 3 = cancel (no data write)
- wb_alu, wb_mem, wb_pc  in  DATA_W each  writeback sources
- wb_dr  in  ADDR_W  destination register
- wb_setcc  in  1  update NZP from the written value
- iss_valid  in  1  issue stage reserves destination iss_dr
- iss_dr  in  ADDR_W  register being reserved
- iss_ready  out  1  reservation of iss_dr can be accepted this cycle
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data
- rd_busy  out  NUM_RD  register at port k has an outstanding write not yet visible
- psr  out  3  {N,Z,P} condition codes
- sb_err  out  1  sticky flag: writeback arrived for a register with a zero counter

## Operation
- Source mux: dr_in = wb_alu, wb_mem or wb_pc, selected by wb_sel 0, 1 or 2.
- Data write: the write is `we = wb_valid & (wb_sel != 3)`. On we, reg[wb_dr] <= dr_in at the edge. Only one write is possible per cycle.
- NZP update: on `we & wb_setcc`, psr <= {dr_in[DATA_W-1], dr_in==0, !dr_in[DATA_W-1] & dr_in!=0}. Exactly one bit is set. Otherwise psr holds.
- Scoreboard: each register has a CNT_W-bit counter cnt[r].
  - iss_fire = iss_valid & iss_ready increments cnt[iss_dr].
  - wb_valid with cnt[wb_dr] != 0 decrements cnt[wb_dr]. This applies to every wb_sel, so a cancel also releases the reservation.
  - Simultaneous iss_fire and wb_valid on the same register leave the counter unchanged; on different registers both apply.
- iss_ready = cnt[iss_dr] != 2**CNT_W-1, or a wb_valid in the same cycle targets iss_dr with a nonzero counter. A saturated counter therefore never wraps.
- Underflow: wb_valid with cnt[wb_dr] == 0 leaves the counter at 0 and sets sb_err. The data write still occurs if we. sb_err clears only on reset.
- Reads: rd_data[k] = reg[rd_addr[k]]. With BYPASS=1 and `we & wb_dr == rd_addr[k]`, rd_data[k] = dr_in instead.
- rd_busy[k] is computed from c = cnt[rd_addr[k]]:
  - BYPASS=1 and a wb_valid in this cycle hits rd_addr[k]: rd_busy[k] = (c > 1).
  - Otherwise: rd_busy[k] = (c != 0).
- Reset (rst low at an edge):
  - all registers 0 and all counters 0
  - psr = 3'b010 (Z)
  - sb_err = 0
  - Reset overrides any same-cycle wb or issue. An in-flight write arriving after reset is an underflow and sets sb_err.

## Timing
- Write latency: 1 cycle. Without BYPASS, a value written at edge t is readable combinationally after edge t. With BYPASS it is readable in the cycle before edge t.
- psr is valid after the edge at which the write occurs; it has no bypass path.
- iss_ready, rd_data and rd_busy are combinational from the current state and same-cycle inputs. There are no combinational paths from iss_* to rd_*.
- The scoreboard counter change becomes visible on iss_ready and rd_busy at the cycle after the edge.
- Outputs after reset: rd_data = 0, rd_busy = 0, iss_ready = 1, psr = 3'b010, sb_err = 0.

## Test plan
- Reset, then write via ALU: wb_sel=0, wb_alu=16'h8001, wb_dr=3, wb_setcc=1 → next cycle reg3 reads 16'h8001 and psr = 3'b100. Write 16'h0000 to reg5 → psr = 3'b010.
- Bypass: BYPASS=1, reg2 = 16'h1111, same cycle wb_pc = 16'h3000 to reg2 with rd_addr port0 = 2 → rd_data[0] = 16'h3000 in that cycle. Rebuild with BYPASS=0 → 16'h1111 that cycle, 16'h3000 next.
- Scoreboard saturation: three iss_fire to reg4 (CNT_W=2) → iss_ready=0 for iss_dr=4. Then a fourth iss_valid together with wb_valid on reg4 → accepted and cnt stays 3. Three more writebacks → rd_busy clears only after the last.
- Cancel: issue reg1, then wb_sel=3 for reg1 with wb_setcc=1 → reg1 and psr unchanged, rd_busy for reg1 = 0.
- Underflow: wb_valid to reg6 with cnt=0 → data written and sb_err=1, which stays 1 until rst=0 for one edge.
- Reset mid-operation: cnt[0]=2, reg0 = 16'hABCD, rst low with a simultaneous wb → all state cleared, reg0 = 0, psr = 3'b010, iss_ready = 1.
